// File: rtl/pulse_gen_multi_if.sv
// Control/status bundle of the multi-channel pulse generator.
// The master side drives strobes and configuration; the slave side returns pulses and overrun flags.
interface pulse_gen_multi_if #(
    parameter int CH   = 32,
    parameter int PW_W = 8
);
    logic            en;
    logic [1:0]      mode;
    logic [PW_W-1:0] pw;
    logic            retrig;
    logic [CH-1:0]   fd;
    logic            ovr_clr;
    logic [CH-1:0]   out;
    logic [CH-1:0]   ovr;

    modport master (
        output en, mode, pw, retrig, fd, ovr_clr,
        input  out, ovr
    );

    modport slave (
        input  en, mode, pw, retrig, fd, ovr_clr,
        output out, ovr
    );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel edge-to-pulse generator: per-channel synchroniser, edge select,
// programmable-width pulse with optional retrigger and sticky overrun flag.
module pulse_gen_lane #(
    parameter int PW_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fd,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [PW_W-1:0] pw_eff,
    input  logic            retrig,
    input  logic            ovr_clr,
    output logic            out,
    output logic            ovr
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [PW_W-1:0]        cnt, cnt_n;
    logic                   out_n, ovr_n, ovr_set;
    logic                   lvl, rise, fall, trig;

    // History keeps tracking even while disabled so re-enable sees no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync[0] <= fd;
            for (int j = 1; j < SYNC_STAGES; j++) sync[j] <= sync[j-1];
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync[SYNC_STAGES-1];
    assign rise = lvl & ~hist;
    assign fall = ~lvl & hist;

    always_comb begin
        case (mode)
            2'b00:   trig = rise;
            2'b01:   trig = fall;
            2'b10:   trig = rise | fall;
            default: trig = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out   <= out_n;
            ovr   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out;
        ovr_set = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            out_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state_n = ACTIVE;
                        cnt_n   = pw_eff;
                        out_n   = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (trig && retrig) begin
                        cnt_n = pw_eff;
                        out_n = 1'b1;
                    end else begin
                        // Dropped edge still lets the pulse finish on its original schedule.
                        ovr_set = trig;
                        if (cnt == {{(PW_W-1){1'b0}}, 1'b1}) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            out_n   = 1'b0;
                        end else begin
                            cnt_n = cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    out_n   = 1'b0;
                end
            endcase
        end
        ovr_n = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr);
    end
endmodule

module pulse_gen_multi #(
    parameter int CH          = 32,
    parameter int PW_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    pulse_gen_multi_if.slave bus
);
    logic [PW_W-1:0] pw_eff;
    logic [CH-1:0]   out_w;
    logic [CH-1:0]   ovr_w;

    // A zero width still produces a one-cycle pulse.
    assign pw_eff = (bus.pw == '0) ? {{(PW_W-1){1'b0}}, 1'b1} : bus.pw;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        pulse_gen_lane #(
            .PW_W       (PW_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .fd     (bus.fd[i]),
            .en     (bus.en),
            .mode   (bus.mode),
            .pw_eff (pw_eff),
            .retrig (bus.retrig),
            .ovr_clr(bus.ovr_clr),
            .out    (out_w[i]),
            .ovr    (ovr_w[i])
        );
    end

    assign bus.out = out_w;
    assign bus.ovr = ovr_w;
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: directed scenarios plus random strobes, checked every
// cycle against a per-channel "cycles remaining" model fed by delayed fd samples.
module tb_pulse_gen_multi;
    localparam int CH   = 32;
    localparam int PW_W = 8;
    localparam int S    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #20 clk = ~clk;

    pulse_gen_multi_if #(.CH(CH), .PW_W(PW_W)) bus();

    pulse_gen_multi #(.CH(CH), .PW_W(PW_W), .SYNC_STAGES(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int rem [CH];
    bit movr[CH];
    bit lvl_q[CH][$];
    int hi_cnt[CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            rem[c]  = 0;
            movr[c] = 1'b0;
            lvl_q[c].delete();
            repeat (S + 2) lvl_q[c].push_back(1'b0);
        end
    endtask

    // A level change of fd becomes a usable edge S clocks after it was first sampled.
    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit now_l, prev_l, trig, set;
            int pwe;
            lvl_q[c].push_front(bus.fd[c]);
            void'(lvl_q[c].pop_back());
            now_l  = lvl_q[c][S];
            prev_l = lvl_q[c][S+1];
            case (bus.mode)
                2'b00:   trig = now_l && !prev_l;
                2'b01:   trig = !now_l && prev_l;
                2'b10:   trig = now_l != prev_l;
                default: trig = 1'b0;
            endcase
            pwe = (bus.pw == 0) ? 1 : int'(bus.pw);
            set = 1'b0;
            if (!bus.en) rem[c] = 0;
            else if (rem[c] == 0) begin
                if (trig) rem[c] = pwe;
            end else if (trig && bus.retrig) rem[c] = pwe;
            else begin
                set = trig;
                rem[c]--;
            end
            if (set) movr[c] = 1'b1;
            else if (bus.ovr_clr) movr[c] = 1'b0;
        end
    endtask

    task automatic cycle();
        logic [CH-1:0] eo, ev;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            eo[c] = rem[c] > 0;
            ev[c] = movr[c];
            hi_cnt[c] += int'(bus.out[c]);
        end
        chk("out", bus.out, eo);
        chk("ovr", bus.ovr, ev);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clr_hi();
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    endtask

    function automatic int sum_hi();
        int s = 0;
        for (int c = 0; c < CH; c++) s += hi_cnt[c];
        return s;
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1; bus.mode = 2'b00; bus.pw = 8'd1; bus.retrig = 1'b0;
        bus.fd = '0; bus.ovr_clr = 1'b0;
        model_reset();
        clr_hi();
        @(negedge clk); @(negedge clk);
        chk("rst_out", bus.out, 32'h0);
        chk("rst_ovr", bus.ovr, 32'h0);
        rst_n = 1'b1;

        // single rise, pw=1
        run(5);
        clr_hi();
        bus.fd[0] = 1'b1;
        run(40);
        chk("t1_len", hi_cnt[0], 1);

        // both edges, pw=10 then pw=0
        bus.fd = '0; run(5);
        bus.mode = 2'b10; bus.pw = 8'd10;
        clr_hi();
        for (int t = 0; t < 4; t++) begin
            bus.fd[5] = ~bus.fd[5];
            run(100);
        end
        chk("t2_pw10", hi_cnt[5], 40);
        bus.pw = 8'd0;
        clr_hi();
        for (int t = 0; t < 2; t++) begin
            bus.fd[5] = ~bus.fd[5];
            run(100);
        end
        chk("t2_pw0", hi_cnt[5], 2);

        // retrigger stretches pulse
        bus.mode = 2'b00; bus.pw = 8'd20; bus.retrig = 1'b1;
        clr_hi();
        bus.fd[1] = 1'b1; run(4); bus.fd[1] = 1'b0; run(4); bus.fd[1] = 1'b1;
        run(40);
        chk("t3_len", hi_cnt[1], 28);
        chk("t3_ovr", 32'(bus.ovr[1]), 32'd0);

        // no retrigger: overrun flagged, pulse on schedule
        bus.retrig = 1'b0;
        clr_hi();
        bus.fd[2] = 1'b1; run(4); bus.fd[2] = 1'b0; run(4); bus.fd[2] = 1'b1;
        run(40);
        chk("t4_len", hi_cnt[2], 20);
        chk("t4_ovr", 32'(bus.ovr[2]), 32'd1);
        bus.ovr_clr = 1'b1; run(1); bus.ovr_clr = 1'b0;
        chk("t4_clr", 32'(bus.ovr[2]), 32'd0);
        bus.fd[2] = 1'b0; run(3);
        bus.fd[2] = 1'b1; run(3);
        bus.fd[2] = 1'b0; run(3);
        bus.fd[2] = 1'b1; run(S);
        bus.ovr_clr = 1'b1; run(1); bus.ovr_clr = 1'b0;
        chk("t4_setwins", 32'(bus.ovr[2]), 32'd1);
        run(30);

        // all channels together, then en drop
        bus.pw = 8'd5;
        bus.fd = '0; run(5);
        clr_hi();
        bus.fd = '1; run(12);
        chk("t5_all", sum_hi(), CH * 5);
        bus.fd = '0; run(12);
        bus.fd = '1; run(S + 2);
        bus.en = 1'b0; run(1);
        chk("t5_endrop", bus.out, 32'h0);
        run(3);
        bus.en = 1'b1;
        clr_hi();
        run(10);
        chk("t5_reen", sum_hi(), 0);

        // async reset mid-pulse, fd held through release
        bus.pw = 8'd20;
        bus.fd = '0; run(5);
        bus.fd[3] = 1'b1; run(S + 3);
        #5 rst_n = 1'b0;
        #1;
        chk("t6_out", bus.out, 32'h0);
        chk("t6_ovr", bus.ovr, 32'h0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        clr_hi();
        run(30);
        chk("t6_relpulse", hi_cnt[3], 20);
        chk("t6_total", sum_hi(), 20);

        // random phase
        for (int n = 0; n < 2500; n++) begin
            bus.fd      = bus.fd ^ ($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.pw      = 8'($urandom_range(0, 12));
            bus.retrig  = 1'($urandom_range(0, 1));
            bus.en      = $urandom_range(0, 49) != 0;
            bus.ovr_clr = $urandom_range(0, 19) == 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
